// File: rtl/branch_predict_ctrl_pkg.sv
// Shared types and constants for the branch prediction / resolution controller.
// Counter encodings, FSM states and the saturating BHT update helper live here.
package branch_predict_ctrl_pkg;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } bht_cnt_e;

    localparam logic [1:0]  BHT_RESET = WNT;
    localparam logic [31:0] PC_INC    = 32'd4;

    typedef enum logic {
        RUN     = 1'b0,
        RECOVER = 1'b1
    } bp_state_e;

    // Two-bit saturating counter step toward taken or not-taken.
    function automatic logic [1:0] bht_next(input logic [1:0] cur, input logic taken);
        logic [1:0] nxt;
        nxt = cur;
        if (taken) begin
            if (cur != ST) nxt = cur + 2'd1;
            else           nxt = cur;
        end else begin
            if (cur != SNT) nxt = cur - 2'd1;
            else            nxt = cur;
        end
        return nxt;
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/branch_predict_ctrl_if.sv
// Pipeline-side bundle of the branch controller: ID lookup, EX resolve and redirect.
// The pipeline drives the master side; the controller is the slave side.
interface branch_predict_ctrl_if #(parameter int PC_W = 32);
    logic            in_stall;
    logic [PC_W-1:0] in_id_pc;
    logic            in_id_is_branch;
    logic            out_pred_taken;
    logic            in_ex_valid;
    logic            in_ex_BEQ;
    logic            in_ex_BNE;
    logic            in_ex_BGEZ;
    logic            in_ex_equal;
    logic            in_ex_result;
    logic [PC_W-1:0] in_ex_pc;
    logic [PC_W-1:0] in_ex_target;
    logic            in_ex_pred_taken;
    logic            out_redirect_valid;
    logic [PC_W-1:0] out_redirect_pc;
    logic            out_flush;
    logic            out_busy;

    modport master (
        output in_stall, in_id_pc, in_id_is_branch, in_ex_valid, in_ex_BEQ, in_ex_BNE,
               in_ex_BGEZ, in_ex_equal, in_ex_result, in_ex_pc, in_ex_target, in_ex_pred_taken,
        input  out_pred_taken, out_redirect_valid, out_redirect_pc, out_flush, out_busy
    );

    modport slave (
        input  in_stall, in_id_pc, in_id_is_branch, in_ex_valid, in_ex_BEQ, in_ex_BNE,
               in_ex_BGEZ, in_ex_equal, in_ex_result, in_ex_pc, in_ex_target, in_ex_pred_taken,
        output out_pred_taken, out_redirect_valid, out_redirect_pc, out_flush, out_busy
    );
endinterface

// File: rtl/branch_predict_ctrl_cond_eval.sv
// Combinational branch condition resolver: BEQ beats BNE beats BGEZ when
// several type bits are set at once.
module branch_cond_eval (
    input  logic is_beq,
    input  logic is_bne,
    input  logic is_bgez,
    input  logic equal,
    input  logic result,
    output logic is_branch,
    output logic taken
);

    // Priority-ordered taken decision.
    always_comb begin
        is_branch = is_beq | is_bne | is_bgez;
        if (is_beq)       taken = equal;
        else if (is_bne)  taken = ~equal;
        else if (is_bgez) taken = result;
        else              taken = 1'b0;
    end

endmodule

// File: rtl/branch_predict_ctrl.sv
// Branch predictor (2-bit BHT) with EX resolution and one-cycle redirect/flush FSM.
// Optional statistics counters are enabled by defining BRANCH_STATS_EN.
module branch_predict_ctrl
    import branch_predict_ctrl_pkg::*;
#(
    parameter int IDX_W = 4,
    parameter int PC_W  = 32
) (
    input  logic                 in_clk,
    input  logic                 in_rst_n,
    branch_predict_ctrl_if.slave bus
`ifdef BRANCH_STATS_EN
    ,
    output logic [15:0]          out_branch_cnt,
    output logic [15:0]          out_mispredict_cnt
`endif
);

    localparam int ENTRIES = 1 << IDX_W;

    logic [1:0]       bht_r [ENTRIES];
    bp_state_e        state_r;
    logic             redirect_valid_r;
    logic             flush_r;
    logic             busy_r;
    logic [PC_W-1:0]  redirect_pc_r;

    logic [IDX_W-1:0] id_idx_s;
    logic [IDX_W-1:0] ex_idx_s;
    logic             ex_is_branch_s;
    logic             ex_taken_s;
    logic             resolve_s;
    logic             mispredict_s;
    logic             unused_id_pc_s;

    branch_cond_eval u_cond (
        .is_beq    (bus.in_ex_BEQ),
        .is_bne    (bus.in_ex_BNE),
        .is_bgez   (bus.in_ex_BGEZ),
        .equal     (bus.in_ex_equal),
        .result    (bus.in_ex_result),
        .is_branch (ex_is_branch_s),
        .taken     (ex_taken_s)
    );

    // Index extraction and resolve/mispredict qualification; RECOVER ignores wrong-path EX.
    always_comb begin
        id_idx_s       = bus.in_id_pc[IDX_W+1:2];
        ex_idx_s       = bus.in_ex_pc[IDX_W+1:2];
        unused_id_pc_s = ^{bus.in_id_pc[PC_W-1:IDX_W+2], bus.in_id_pc[1:0]};
        resolve_s      = bus.in_ex_valid & ex_is_branch_s & ~bus.in_stall & (state_r == RUN);
        mispredict_s   = resolve_s & (ex_taken_s != bus.in_ex_pred_taken);
    end

    // ID reads the registered table, so a same-cycle EX update is not bypassed.
    assign bus.out_pred_taken     = bus.in_id_is_branch & bht_r[id_idx_s][1];
    assign bus.out_redirect_valid = redirect_valid_r;
    assign bus.out_flush          = flush_r;
    assign bus.out_busy           = busy_r;
    assign bus.out_redirect_pc    = redirect_pc_r;

    // BHT: reset to weakly not-taken, saturating update on each resolve.
    always_ff @(posedge in_clk) begin
        if (!in_rst_n) begin
            for (int i = 0; i < ENTRIES; i++) bht_r[i] <= BHT_RESET;
        end else if (resolve_s) begin
            bht_r[ex_idx_s] <= bht_next(bht_r[ex_idx_s], ex_taken_s);
        end
    end

    // Recovery FSM with registered redirect, flush and busy outputs.
    always_ff @(posedge in_clk) begin
        if (!in_rst_n) begin
            state_r          <= RUN;
            redirect_valid_r <= 1'b0;
            flush_r          <= 1'b0;
            busy_r           <= 1'b0;
            redirect_pc_r    <= {PC_W{1'b0}};
        end else begin
            case (state_r)
                RUN: begin
                    if (mispredict_s) begin
                        state_r          <= RECOVER;
                        redirect_valid_r <= 1'b1;
                        flush_r          <= 1'b1;
                        busy_r           <= 1'b1;
                        redirect_pc_r    <= ex_taken_s ? bus.in_ex_target
                                                       : bus.in_ex_pc + PC_W'(PC_INC);
                    end else begin
                        state_r          <= RUN;
                        redirect_valid_r <= 1'b0;
                        flush_r          <= 1'b0;
                        busy_r           <= 1'b0;
                    end
                end
                RECOVER: begin
                    state_r          <= RUN;
                    redirect_valid_r <= 1'b0;
                    flush_r          <= 1'b0;
                    busy_r           <= 1'b0;
                end
                default: begin
                    state_r          <= RUN;
                    redirect_valid_r <= 1'b0;
                    flush_r          <= 1'b0;
                    busy_r           <= 1'b0;
                end
            endcase
        end
    end

`ifdef BRANCH_STATS_EN
    logic [15:0] branch_cnt_r;
    logic [15:0] mispredict_cnt_r;

    // Saturating resolve and mispredict counters.
    always_ff @(posedge in_clk) begin
        if (!in_rst_n) begin
            branch_cnt_r     <= 16'h0000;
            mispredict_cnt_r <= 16'h0000;
        end else begin
            if (resolve_s)    branch_cnt_r     <= sat_inc16(branch_cnt_r);
            if (mispredict_s) mispredict_cnt_r <= sat_inc16(mispredict_cnt_r);
        end
    end

    assign out_branch_cnt     = branch_cnt_r;
    assign out_mispredict_cnt = mispredict_cnt_r;
`endif

endmodule

// File: tb/tb_branch_predict_ctrl.sv
// Self-checking bench for branch_predict_ctrl: a reference model pushes expected
// redirect/flush/busy state per cycle into a queue that each test pops and compares.
module tb_branch_predict_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    branch_predict_ctrl_if #(.PC_W(32)) bus ();

`ifdef BRANCH_STATS_EN
    logic [15:0] branch_cnt;
    logic [15:0] mispredict_cnt;
`endif

    branch_predict_ctrl #(.IDX_W(4), .PC_W(32)) dut (
        .in_clk   (clk),
        .in_rst_n (rst_n),
        .bus      (bus)
`ifdef BRANCH_STATS_EN
        ,
        .out_branch_cnt     (branch_cnt),
        .out_mispredict_cnt (mispredict_cnt)
`endif
    );

    int          total_cnt = 0;
    int          pass_cnt  = 0;
    logic [1:0]  bht_m [16];
    logic        rec_m = 1'b0;
    logic [31:0] pc_m  = 32'h0;
    int          bcnt_m = 0;
    int          mcnt_m = 0;
    logic [34:0] sb_q [$];
    logic [34:0] exp_v;
    logic [34:0] act_v;
    logic        exp_pred;

    task automatic clear_ex();
        bus.in_ex_valid = 1'b0; bus.in_ex_BEQ = 1'b0; bus.in_ex_BNE = 1'b0; bus.in_ex_BGEZ = 1'b0;
        bus.in_ex_equal = 1'b0; bus.in_ex_result = 1'b0; bus.in_ex_pred_taken = 1'b0;
        bus.in_ex_pc = 32'h0; bus.in_ex_target = 32'h0; bus.in_stall = 1'b0;
    endtask

    task automatic drive_ex(input logic beq, input logic bne, input logic bgez, input logic eq,
                            input logic res, input logic pred, input logic [31:0] pc,
                            input logic [31:0] tgt);
        bus.in_ex_valid = 1'b1; bus.in_ex_BEQ = beq; bus.in_ex_BNE = bne; bus.in_ex_BGEZ = bgez;
        bus.in_ex_equal = eq; bus.in_ex_result = res; bus.in_ex_pred_taken = pred;
        bus.in_ex_pc = pc; bus.in_ex_target = tgt;
    endtask

    // Advance the model by one clock using the currently driven inputs, queue the expectation, clock the DUT.
    task automatic tick();
        logic       isb, tk, rs;
        logic [3:0] idx;
        isb = bus.in_ex_BEQ | bus.in_ex_BNE | bus.in_ex_BGEZ;
        tk  = bus.in_ex_BEQ ? bus.in_ex_equal : bus.in_ex_BNE ? !bus.in_ex_equal :
              bus.in_ex_BGEZ ? bus.in_ex_result : 1'b0;
        rs  = bus.in_ex_valid & isb & !bus.in_stall & !rec_m;
        idx = bus.in_ex_pc[5:2];
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) bht_m[i] = 2'b01;
            rec_m = 1'b0; pc_m = 32'h0; bcnt_m = 0; mcnt_m = 0;
            sb_q.push_back({3'b000, 32'h0});
        end else if (rec_m) begin
            rec_m = 1'b0;
            sb_q.push_back({3'b000, pc_m});
        end else begin
            if (rs) begin
                if (bcnt_m < 65535) bcnt_m++;
                if (tk && bht_m[idx] != 2'b11) bht_m[idx] = bht_m[idx] + 2'd1;
                else if (!tk && bht_m[idx] != 2'b00) bht_m[idx] = bht_m[idx] - 2'd1;
                if (tk != bus.in_ex_pred_taken) begin
                    rec_m = 1'b1;
                    if (mcnt_m < 65535) mcnt_m++;
                    pc_m = tk ? bus.in_ex_target : bus.in_ex_pc + 32'd4;
                end
            end
            sb_q.push_back({rec_m, rec_m, rec_m, pc_m});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; clear_ex(); bus.in_id_pc = 32'h0; bus.in_id_is_branch = 1'b0;
        tick(); tick();
        for (int k = 0; k < 2; k++) begin
            exp_v = sb_q.pop_front();
            act_v = {bus.out_redirect_valid, bus.out_flush, bus.out_busy, bus.out_redirect_pc};
            total_cnt++;
            if (act_v !== exp_v) $display("FAIL reset_outputs: got %h expected %h", act_v, exp_v);
            else pass_cnt++;
        end
        rst_n = 1'b1;
        for (int i = 0; i < 16; i++) begin
            bus.in_id_pc = 32'h40 + 32'(i * 4); bus.in_id_is_branch = 1'b1;
            #1;
            total_cnt++;
            if (bus.out_pred_taken !== 1'b0) $display("FAIL reset_pred[%0d]: got %b expected 0", i, bus.out_pred_taken);
            else pass_cnt++;
        end
    endtask

    task automatic test_beq_mispredict();
        bus.in_id_pc = 32'h40; bus.in_id_is_branch = 1'b1;
        drive_ex(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h40, 32'h80);
        tick();
        exp_v = sb_q.pop_front();
        act_v = {bus.out_redirect_valid, bus.out_flush, bus.out_busy, bus.out_redirect_pc};
        total_cnt++;
        if (act_v !== exp_v || act_v !== {3'b111, 32'h80}) $display("FAIL beq_redirect: got %h expected %h", act_v, {3'b111, 32'h80});
        else pass_cnt++;
        clear_ex();
        tick();
        exp_v = sb_q.pop_front();
        act_v = {bus.out_redirect_valid, bus.out_flush, bus.out_busy, bus.out_redirect_pc};
        total_cnt++;
        if (act_v !== exp_v) $display("FAIL beq_recover_end: got %h expected %h", act_v, exp_v);
        else pass_cnt++;
        total_cnt++;
        if (bus.out_pred_taken !== 1'b1) $display("FAIL beq_bht_wt: got %b expected 1", bus.out_pred_taken);
        else pass_cnt++;
    endtask

    task automatic test_bne_saturate();
        bus.in_id_pc = 32'h44; bus.in_id_is_branch = 1'b1;
        for (int k = 0; k < 2; k++) begin
            drive_ex(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h44, 32'h100);
            tick();
            exp_v = sb_q.pop_front();
            act_v = {bus.out_redirect_valid, bus.out_flush, bus.out_busy, bus.out_redirect_pc};
            total_cnt++;
            if (act_v !== exp_v || bus.out_redirect_valid !== 1'b0) $display("FAIL bne_no_redirect[%0d]: got %h expected %h", k, act_v, exp_v);
            else pass_cnt++;
        end
        total_cnt++;
        if (bus.out_pred_taken !== 1'b0) $display("FAIL bne_sat_pred: got %b expected 0", bus.out_pred_taken);
        else pass_cnt++;
        // One taken step from a saturated 00 must leave the entry below the taken half.
        drive_ex(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h44, 32'h100);
        tick();
        clear_ex();
        tick();
        for (int k = 0; k < 2; k++) begin
            exp_v = sb_q.pop_front();
            total_cnt++;
            if (exp_v[34] !== (k == 0)) $display("FAIL bne_taken_seq[%0d]: model redirect %b", k, exp_v[34]);
            else pass_cnt++;
        end
        total_cnt++;
        if (bus.out_pred_taken !== 1'b0) $display("FAIL bne_after_sat: got %b expected 0", bus.out_pred_taken);
        else pass_cnt++;
    endtask

    task automatic test_bgez_recover();
        drive_ex(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h48, 32'h200);
        tick();
        exp_v = sb_q.pop_front();
        act_v = {bus.out_redirect_valid, bus.out_flush, bus.out_busy, bus.out_redirect_pc};
        total_cnt++;
        if (act_v !== exp_v || act_v !== {3'b111, 32'h4C}) $display("FAIL bgez_redirect: got %h expected %h", act_v, {3'b111, 32'h4C});
        else pass_cnt++;
        drive_ex(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h50, 32'h300);
        tick();
        clear_ex();
        tick();
        for (int k = 0; k < 2; k++) begin
            exp_v = sb_q.pop_front();
            total_cnt++;
            if (k == 1) act_v = {bus.out_redirect_valid, bus.out_flush, bus.out_busy, bus.out_redirect_pc};
            if (exp_v[34:32] !== 3'b000) $display("FAIL bgez_ignore_model[%0d]: model %h", k, exp_v);
            else pass_cnt++;
        end
        total_cnt++;
        if (act_v !== {3'b000, 32'h4C}) $display("FAIL bgez_no_second_redirect: got %h expected %h", act_v, {3'b000, 32'h4C});
        else pass_cnt++;
        bus.in_id_pc = 32'h50; bus.in_id_is_branch = 1'b1;
        #1;
        total_cnt++;
        if (bus.out_pred_taken !== 1'b0) $display("FAIL bgez_recover_no_update: got %b expected 0", bus.out_pred_taken);
        else pass_cnt++;
    endtask

    task automatic test_stall();
        drive_ex(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h60, 32'hA0);
        bus.in_stall = 1'b1;
        tick(); tick();
        bus.in_stall = 1'b0;
        tick();
        clear_ex();
        tick();
        for (int k = 0; k < 4; k++) begin
            exp_v = sb_q.pop_front();
            total_cnt++;
            if (exp_v[34] !== (k == 2)) $display("FAIL stall_model_seq[%0d]: model %h", k, exp_v);
            else pass_cnt++;
        end
        act_v = {bus.out_redirect_valid, bus.out_flush, bus.out_busy, bus.out_redirect_pc};
        total_cnt++;
        if (act_v !== {3'b000, 32'hA0}) $display("FAIL stall_final: got %h expected %h", act_v, {3'b000, 32'hA0});
        else pass_cnt++;
        // A not-taken step must drop the entry back to 01 if exactly one stalled update happened.
        drive_ex(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h60, 32'hA0);
        tick();
        clear_ex();
        tick();
        void'(sb_q.pop_front()); void'(sb_q.pop_front());
        bus.in_id_pc = 32'h60; bus.in_id_is_branch = 1'b1;
        #1;
        total_cnt++;
        if (bus.out_pred_taken !== 1'b0) $display("FAIL stall_single_update: got %b expected 0", bus.out_pred_taken);
        else pass_cnt++;
    endtask

    task automatic test_same_index();
        bus.in_id_pc = 32'h0C; bus.in_id_is_branch = 1'b1;
        drive_ex(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0C, 32'h400);
        #1;
        total_cnt++;
        if (bus.out_pred_taken !== 1'b0) $display("FAIL same_idx_pre: got %b expected 0", bus.out_pred_taken);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (bus.out_pred_taken !== 1'b1) $display("FAIL same_idx_post: got %b expected 1", bus.out_pred_taken);
        else pass_cnt++;
        exp_v = sb_q.pop_front();
        act_v = {bus.out_redirect_valid, bus.out_flush, bus.out_busy, bus.out_redirect_pc};
        total_cnt++;
        if (act_v !== exp_v) $display("FAIL same_idx_redirect: got %h expected %h", act_v, exp_v);
        else pass_cnt++;
        clear_ex();
        tick();
        void'(sb_q.pop_front());
    endtask

    task automatic test_wrap();
        drive_ex(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC, 32'h1234);
        tick();
        exp_v = sb_q.pop_front();
        act_v = {bus.out_redirect_valid, bus.out_flush, bus.out_busy, bus.out_redirect_pc};
        total_cnt++;
        if (act_v !== exp_v || act_v !== {3'b111, 32'h0}) $display("FAIL pc_wrap: got %h expected %h", act_v, {3'b111, 32'h0});
        else pass_cnt++;
        clear_ex();
        tick();
        void'(sb_q.pop_front());
    endtask

    task automatic test_random();
        logic [2:0] ty;
        for (int n = 0; n < 100; n++) begin
            ty = 3'($urandom_range(1, 7));
            drive_ex(ty[0], ty[1], ty[2], 1'($urandom), 1'($urandom), 1'($urandom),
                     {$urandom} & 32'hFFFF_FFFC, {$urandom} & 32'hFFFF_FFFC);
            bus.in_ex_valid = ($urandom_range(0, 7) != 0);
            bus.in_stall = ($urandom_range(0, 5) == 0);
            bus.in_id_pc = {$urandom}; bus.in_id_is_branch = 1'($urandom);
            #1;
            exp_pred = bus.in_id_is_branch & bht_m[bus.in_id_pc[5:2]][1];
            total_cnt++;
            if (bus.out_pred_taken !== exp_pred) $display("FAIL rand_pred[%0d]: got %b expected %b", n, bus.out_pred_taken, exp_pred);
            else pass_cnt++;
            tick();
            exp_v = sb_q.pop_front();
            act_v = {bus.out_redirect_valid, bus.out_flush, bus.out_busy, bus.out_redirect_pc};
            total_cnt++;
            if (act_v !== exp_v) $display("FAIL rand_redirect[%0d]: got %h expected %h", n, act_v, exp_v);
            else pass_cnt++;
        end
        clear_ex();
        tick();
        void'(sb_q.pop_front());
`ifdef BRANCH_STATS_EN
        total_cnt++;
        if (branch_cnt !== 16'(bcnt_m)) $display("FAIL stats_branch: got %0d expected %0d", branch_cnt, bcnt_m);
        else pass_cnt++;
        total_cnt++;
        if (mispredict_cnt !== 16'(mcnt_m)) $display("FAIL stats_mispredict: got %0d expected %0d", mispredict_cnt, mcnt_m);
        else pass_cnt++;
`endif
    endtask

    initial begin
        test_reset();
        test_beq_mispredict();
        test_bne_saturate();
        test_bgez_recover();
        test_stall();
        test_same_index();
        test_wrap();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/branch_predict_ctrl.md
Name: branch_predict_ctrl

Overview:
- Branch prediction and resolution controller for the 5-stage pipeline.
- Holds a table of 2-bit saturating counters (BHT), indexed by PC, that gives an ID-stage taken/not-taken prediction.
- Resolves BEQ/BNE/BGEZ in EX and updates the BHT.
- Sequences PC redirect and IF/ID flush after a mispredict.

Parameters:
- IDX_W, 4, BHT index width (2^IDX_W entries); index = pc[IDX_W+1:2].
- PC_W, 32, PC and target width.

Ports:
- in_clk  input  1  clock; all state updates on rising edge.
- in_rst_n  input  1  synchronous active-low reset.
- in_stall  input  1  pipeline stall; EX contents are held and will be re-presented.
- in_id_pc  input  PC_W  PC of the instruction in ID.
- in_id_is_branch  input  1  ID instruction is BEQ/BNE/BGEZ.
- out_pred_taken  output  1  prediction for the ID instruction (combinational).
- in_ex_valid  input  1  EX holds a valid instruction.
- in_ex_BEQ  input  1  EX instruction is BEQ.
- in_ex_BNE  input  1  EX instruction is BNE.
- in_ex_BGEZ  input  1  EX instruction is BGEZ.
- in_ex_equal  input  1  ALU equal flag.
- in_ex_result  input  1  BGEZ condition (rs >= 0).
- in_ex_pc  input  PC_W  PC of the EX instruction.
- in_ex_target  input  PC_W  computed branch target.
- in_ex_pred_taken  input  1  prediction carried down the pipe with the instruction.
- out_redirect_valid  output  1  load out_redirect_pc into the PC.
- out_redirect_pc  output  PC_W  correct next PC.
- out_flush  output  1  squash the IF/ID and ID/EX registers.
- out_busy  output  1  FSM is in RECOVER.

Behaviour:
- Clock and reset:
  - Single clock in_clk; reset in_rst_n is synchronous, active-low.
- Reset:
  - All BHT entries = 2'b01 (weakly not-taken); FSM = RUN.
  - out_redirect_valid = 0, out_flush = 0, out_busy = 0, out_redirect_pc = 0.
  - Reset mid-RECOVER aborts the recovery; no redirect is issued.
- Prediction:
  - out_pred_taken = in_id_is_branch & BHT[in_id_pc[IDX_W+1:2]][1].
  - Zero latency.
  - If ID lookup and EX update hit the same index in one cycle, ID reads the pre-update value (no bypass).
- Resolution (combinational), in priority order:
  - BEQ taken = equal.
  - Else BNE taken = ~equal.
  - Else BGEZ taken = result.
  - Multiple type bits asserted at once: highest-priority type wins.
- Resolve event:
  - resolve = in_ex_valid & (BEQ | BNE | BGEZ) & ~in_stall & state == RUN.
- BHT update on a resolve event:
  - Increment entry at in_ex_pc index if taken, else decrement.
  - Saturate at 2'b11 and 2'b00.
  - No update when there is no resolve event, including during RECOVER and during stall.
- Mispredict:
  - mispredict = resolve & (taken != in_ex_pred_taken).
- FSM RUN:
  - On mispredict: register out_redirect_pc = taken ? in_ex_target : in_ex_pc + 4 (mod 2^PC_W, wraps), then go to RECOVER.
  - Otherwise stay in RUN.
  - Correct predictions cause no redirect.
- FSM RECOVER (exactly 1 cycle):
  - out_redirect_valid = 1, out_flush = 1, out_busy = 1, all registered.
  - EX inputs are treated as wrong-path and ignored.
  - Return to RUN unconditionally; in_stall does not extend RECOVER.
- Latency:
  - Redirect/flush is asserted in the cycle after the mispredicting branch is in EX.
- Non-branch EX instructions and in_ex_valid = 0 have no effect.

Optional Feature:
- Macro BRANCH_STATS_EN.
- Defined:
  - Adds outputs out_branch_cnt[15:0] and out_mispredict_cnt[15:0].
  - Each resolve event increments out_branch_cnt; each mispredict increments out_mispredict_cnt.
  - Both saturate at 16'hFFFF; both reset to 0.
- Undefined:
  - Ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package holds:
  - Counter encodings: SNT = 2'b00, WNT = 2'b01, WT = 2'b10, ST = 2'b11.
  - BHT_RESET = WNT.
  - FSM state typedef {RUN, RECOVER}.
  - Constant PC_INC = 4.
- One natural sub-module: branch_cond_eval, the combinational priority condition resolver.
- Remaining logic (BHT array, FSM, redirect register, optional stats counters) lives in the top level.

Test Plan:
- Reset, then ID branch at pc 0x40 -> out_pred_taken = 0; every entry reads 01.
- BEQ at 0x40, equal = 1, pred = 0 -> next cycle redirect_valid = 1, flush = 1, redirect_pc = in_ex_target (0x80); BHT[0] = 10; following cycle both outputs are 0.
- BNE at 0x44, equal = 1, pred = 0 -> no redirect; BHT[1] 01 -> 00; a second identical BNE keeps BHT[1] at 00 (saturation).
- BGEZ at 0x48, result = 0, pred = 1 -> redirect_pc = 0x4C; during the RECOVER cycle a valid BEQ in EX is ignored (no BHT update, no second redirect).
- in_stall = 1 with a mispredicting BEQ in EX -> no redirect and no update; on stall release -> redirect issued once.
- Simultaneous ID lookup and EX update at index 3, entry = 01, EX taken -> out_pred_taken = 0 that cycle, 1 the next; with BRANCH_STATS_EN defined, branch_cnt and mispredict_cnt match a scoreboard after 100 random branches.
